// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the MEM-stage load/store unit.
// The master side is the pipeline plus data memory; the slave side is the unit itself.
interface mem_access_unit_if #(
  parameter int unsigned AW = 12
) ();
  logic          req_valid;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          busy;
  logic          rdata_valid;
  logic [31:0]   rdata;
  logic          addr_err;
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    input  busy, rdata_valid, rdata, addr_err, dm_addr, dm_we, dm_be, dm_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    output busy, rdata_valid, rdata, addr_err, dm_addr, dm_we, dm_be, dm_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: byte-addressed CPU accesses become word-indexed
// data-memory beats; unaligned stores go out as single-byte beats, split loads read two words.
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned AW          = 12
) (
  input  logic             clk_i,
  input  logic             reset_i,
  mem_access_unit_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr, StErr} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
  } beat_t;

  state_e        state_q;
  logic [1:0]    beat_q, size_q, off_q;
  logic          write_q, signed_q;
  logic [AW-1:0] word_q;
  logic [31:0]   wdata_q, lo_q, rdata_q;
  logic          rdata_valid_q, addr_err_q;
  logic          dm_we_q;
  logic [AW-1:0] dm_addr_q;
  logic [3:0]    dm_be_q;
  logic [31:0]   dm_wdata_q;

  // Byte count minus one for a size code.
  function automatic logic [1:0] nm1_of(logic [1:0] size);
    logic [1:0] r;
    unique case (size)
      2'd0:    r = 2'd0;
      2'd1:    r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] last_beat(logic [1:0] size, logic [1:0] off);
    logic [1:0] r;
    r = 2'd0;
    if (size == 2'd1 && off[0]) r = 2'd1;
    if (size == 2'd2 && off != 2'd0) r = 2'd3;
    return r;
  endfunction

  // Beat idx of a store; aligned half/word are a single wide beat, all else is byte-wise.
  function automatic beat_t beat_calc(logic [AW-1:0] word, logic [1:0] off, logic [1:0] size,
                                      logic [1:0] idx, logic [31:0] wd);
    beat_t      b;
    logic [2:0] pos;
    logic [7:0] byte_v;
    pos    = {1'b0, off} + {1'b0, idx};
    byte_v = wd[{idx, 3'b000} +: 8];
    b.addr = word + AW'(pos[2]);
    b.be   = 4'b0001 << pos[1:0];
    b.data = {4{byte_v}};
    if (size == 2'd2 && off == 2'd0) begin
      b.be   = 4'b1111;
      b.data = wd;
    end else if (size == 2'd1 && !off[0]) begin
      b.be   = off[1] ? 4'b1100 : 4'b0011;
      b.data = {2{wd[15:0]}};
    end
    return b;
  endfunction

  function automatic logic [31:0] extract(logic [63:0] pair, logic [1:0] off, logic [1:0] size,
                                          logic sgn);
    logic [31:0] sh;
    logic [31:0] r;
    sh = pair[{off, 3'b000} +: 32];
    unique case (size)
      2'd0:    r = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    r = {{16{sgn & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  logic [1:0]  req_off, req_nm1;
  logic        req_cross, req_ok, rd_split;
  logic [30:0] req_last_word;
  beat_t       first_beat, next_beat;

  always_comb begin
    req_off       = bus_io.req_addr[1:0];
    req_nm1       = nm1_of(bus_io.req_size);
    req_cross     = ({1'b0, req_off} + {1'b0, req_nm1}) > 3'd3;
    req_last_word = {1'b0, bus_io.req_addr[31:2]} + {30'b0, req_cross};
    req_ok        = (bus_io.req_size != 2'd3) && (req_last_word < 31'(DEPTH_WORDS));
    rd_split      = ({1'b0, off_q} + {1'b0, nm1_of(size_q)}) > 3'd3;
    first_beat    = beat_calc(bus_io.req_addr[AW+1:2], req_off, bus_io.req_size, 2'd0,
                              bus_io.req_wdata);
    next_beat     = beat_calc(word_q, off_q, size_q, beat_q + 2'd1, wdata_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      size_q        <= '0;
      off_q         <= '0;
      write_q       <= 1'b0;
      signed_q      <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      lo_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_be_q       <= '0;
      dm_wdata_q    <= '0;
    end else begin
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.req_valid) begin
            write_q  <= bus_io.req_write;
            size_q   <= bus_io.req_size;
            signed_q <= bus_io.req_signed;
            off_q    <= req_off;
            word_q   <= bus_io.req_addr[AW+1:2];
            wdata_q  <= bus_io.req_wdata;
            beat_q   <= '0;
            if (!req_ok) begin
              state_q <= StErr;
            end else if (bus_io.req_write) begin
              state_q    <= StWr;
              dm_we_q    <= 1'b1;
              dm_addr_q  <= first_beat.addr;
              dm_be_q    <= first_beat.be;
              dm_wdata_q <= first_beat.data;
            end else begin
              state_q   <= StRd0;
              dm_addr_q <= bus_io.req_addr[AW+1:2];
            end
          end
        end
        StRd0: begin
          lo_q <= bus_io.dm_rdata;
          if (rd_split) begin
            state_q   <= StRd1;
            dm_addr_q <= word_q + AW'(1);
          end else begin
            state_q       <= StIdle;
            rdata_q       <= extract({32'b0, bus_io.dm_rdata}, off_q, size_q, signed_q);
            rdata_valid_q <= 1'b1;
            dm_addr_q     <= '0;
          end
        end
        StRd1: begin
          state_q       <= StIdle;
          rdata_q       <= extract({bus_io.dm_rdata, lo_q}, off_q, size_q, signed_q);
          rdata_valid_q <= 1'b1;
          dm_addr_q     <= '0;
        end
        StWr: begin
          if (beat_q == last_beat(size_q, off_q)) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
          end else begin
            beat_q     <= beat_q + 2'd1;
            dm_addr_q  <= next_beat.addr;
            dm_be_q    <= next_beat.be;
            dm_wdata_q <= next_beat.data;
          end
        end
        StErr: begin
          state_q    <= StIdle;
          addr_err_q <= 1'b1;
          if (!write_q) begin
            rdata_valid_q <= 1'b1;
            rdata_q       <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.rdata_valid = rdata_valid_q;
  assign bus_io.rdata       = rdata_q;
  assign bus_io.addr_err    = addr_err_q;
  assign bus_io.dm_addr     = dm_addr_q;
  // A beat coinciding with reset is dropped so an aborted store never lands its next byte.
  assign bus_io.dm_we       = dm_we_q & ~reset_i;
  assign bus_io.dm_be       = dm_be_q;
  assign bus_io.dm_wdata    = dm_wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store initiator that turns CPU byte-addressed loads and stores into word-indexed requests for the data memory. The data memory accepts only word address, write enable, 4-bit byte enable and write data, and returns a combinational read word. This block computes byte enables, lane-aligns store data, splits unaligned accesses into legal beats, and extracts and extends load data. It stalls the pipeline with `busy` while a multi-beat access is in flight.

## Interface
- `DEPTH_WORDS`, 3072: number of 32-bit words in data memory.
- `AW`, 12: width of word address (ceil log2 `DEPTH_WORDS`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present; accepted on an edge where `busy`=0.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed` in 1: sign-extend load result (ignored for word loads and stores).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `busy` out 1: equals state≠IDLE; requests are ignored while high.
- `rdata_valid` out 1: one-cycle pulse carrying a load result or an error completion.
- `rdata` out 32: extended load result; held until the next `rdata_valid`.
- `addr_err` out 1: one-cycle pulse, coincident with completion, for an out-of-range or illegal request.
- `dm_addr` out AW: word address to data memory.
- `dm_we` out 1: memory write enable.
- `dm_be` out 4: byte enable; legal values only 1111, 0011, 1100, 0001, 0010, 0100, 1000; 0000 on reads/idle.
- `dm_wdata` out 32: lane-aligned write data.
- `dm_rdata` in 32: combinational read data for `dm_addr`.

## Operation
- Offset o = `req_addr`[1:0]; word index w = `req_addr`[31:2]; byte count n = 1/2/4.
- Request is rejected when `req_size`=3, or when any touched word ≥ `DEPTH_WORDS` (including w+1 on a crossing). A rejected request performs no DM beats, goes to ERR, and completes next cycle with `addr_err`=1. Loads also return `rdata_valid`=1 with `rdata`=0.
- Stores are latched at acceptance. Beats are driven from registers in state WR:
  - Aligned word (o=0): one beat, be 1111.
  - Aligned half (o∈{0,2}): one beat, be 0011 or 1100; data in the matching lanes.
  - Byte: one beat, be = 0001<<o; data replicated or placed in lane o.
  - Unaligned half/word: n single-byte beats in ascending byte address, least significant byte first. `dm_addr` increments when the byte address crosses into word w+1.
- Loads:
  - If o+n≤4: state RD0 reads word w.
  - Otherwise: RD0 reads w, then RD1 reads w+1.
  - `dm_rdata` is captured at the end of each read cycle.
  - Result = ({w+1 data, w data} >> 8·o) truncated to n bytes, then sign-extended if `req_signed`, else zero-extended.
- States: IDLE → RD0 → (RD1) → IDLE; IDLE → WR (beat counter 0..n-1) → IDLE; IDLE → ERR → IDLE.
- `rdata_valid`/`rdata` are registered and update on the edge leaving the last read state or ERR.

## Timing
- Request accepted at edge ending cycle A.
- Single-word load: RD0 in A+1; `rdata_valid` in A+2; `busy` high only in A+1.
- Split load: RD0 in A+1, RD1 in A+2, `rdata_valid` in A+3.
- Store of k beats: `dm_we`=1 in A+1..A+k; memory updates at each of those edges; `busy` low in A+k+1.
- A new request may be accepted in the same cycle `rdata_valid` pulses (state is IDLE).
- `req_*` changes while `busy`=1 have no effect; the latched copy is used.
- Reset values: `busy`=0, `rdata_valid`=0, `rdata`=0, `addr_err`=0, `dm_we`=0, `dm_be`=0, `dm_addr`=0, `dm_wdata`=0; state IDLE, beat counter 0.
- Reset mid-operation: FSM returns to IDLE on that edge. Remaining beats are dropped; beats already written stay written. No `rdata_valid` is produced for the aborted load.
- Boundary: access ending exactly at byte 4·`DEPTH_WORDS`−1 is legal; one byte further is an error. Address 0 offset 3 word load reads words 0 and 1.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 → one write beat be=1111, `dm_addr`=4; `rdata`=0xDEADBEEF two cycles after acceptance.
- Half store 0x1234 at 0x22, then lh 0x22 and lbu 0x23 → be=1100; lh returns 0x00001234; lbu returns 0x00000012.
- Byte 0x80 at 0x31: lb returns 0xFFFFFF80, lbu returns 0x00000080.
- Unaligned word store 0x11223344 at 0x41 → four beats: addr 0x10 be 0010/0100/1000, then addr 0x11 be 0001. Word load at 0x41 takes RD0+RD1 and returns 0x11223344 in A+3.
- Half load at byte 4·3072−1 (crosses end) and `req_size`=3 → no `dm_we`, `addr_err`=1 and `rdata_valid`=1 with `rdata`=0 in A+2.
- `reset` asserted in the 2nd beat of an unaligned word store → only the first byte is written. `busy`=0 and all DM outputs are 0 on the following cycle.
